mult_seq_ctrl: RTL and testbench
================================

Name: mult_seq_ctrl

Overview:
- Control FSM that sequences an N-bit signed shift-add multiplier.
- Datapath: accumulator register A, multiplier shift register B, the existing adder, and a sign/X bit.
- This block issues one-cycle clear, load, add, subtract and shift strobes; the datapath owns all data.
- Sits between the synchronized run and clear_load buttons and the multiplier datapath in the lab top level.

Parameters:
- N_BITS, 8, number of multiplier bits, which is the number of add/shift iterations.
- CNT_W, $clog2(N_BITS), width of the iteration counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- run_i  input  1  synchronized, debounced run button, active-high level.
- clear_load_i  input  1  synchronized clear-and-load request, active-high level.
- m_i  input  1  current LSB of multiplier register B.
- clr_a_o  output  1  clear A and X this cycle.
- ld_b_o  output  1  load B from switches this cycle.
- add_o  output  1  A <= A + S this cycle.
- sub_o  output  1  A <= A - S this cycle.
- shift_o  output  1  arithmetic right shift of {X,A,B} this cycle.
- busy_o  output  1  high in CLR, ADD and SHIFT.
- done_o  output  1  high in HOLD.
- bit_cnt_o  output  CNT_W  current iteration index.

Behaviour:
- States: IDLE, CLR, ADD, SHIFT, HOLD. State is registered.
- Strobes are combinational from state, bit_cnt and m_i. At most one of add_o, sub_o, shift_o, clr_a_o is high in any cycle; ld_b_o may coincide only with clr_a_o.
- Reset (any state, any cycle):
  - state=IDLE, bit_cnt=0, run_q=1.
  - All strobes 0 in the reset cycle; busy_o=0, done_o=0.
  - An operation in progress is abandoned. There is no partial completion.
- Start detect:
  - run_q <= run_i every cycle.
  - start = run_i & ~run_q.
  - run_q resets to 1, so a button held through reset does not start an operation.
- IDLE:
  - start -> CLR.
  - else if clear_load_i: clr_a_o=1 and ld_b_o=1 every cycle it is held; stay in IDLE.
  - If start and clear_load_i occur in the same cycle, start wins and ld_b_o=0.
- CLR (1 cycle):
  - clr_a_o=1, bit_cnt <= 0, -> ADD.
- ADD (1 cycle):
  - If m_i=1 and bit_cnt<N_BITS-1: add_o=1.
  - If m_i=1 and bit_cnt==N_BITS-1: sub_o=1 (two's-complement sign-bit correction).
  - If m_i=0: no strobe.
  - -> SHIFT.
- SHIFT (1 cycle):
  - shift_o=1.
  - If bit_cnt==N_BITS-1: -> HOLD; bit_cnt holds at N_BITS-1.
  - Else: bit_cnt <= bit_cnt+1, -> ADD.
- HOLD:
  - done_o=1, no strobes.
  - Stays while run_i=1; run_i=0 -> IDLE.
  - clear_load_i is ignored in HOLD.
- Input handling while busy: run_i and clear_load_i are ignored in CLR, ADD and SHIFT; a re-press has no effect.
- Latency: if start is sampled at edge k, then:
  - CLR occupies cycle k+1.
  - ADD_i occupies cycle k+2+2i and SHIFT_i occupies cycle k+3+2i.
  - HOLD begins at cycle k+2+2*N_BITS, i.e. k+18 for N=8.
  - Total busy cycles = 1+2*N_BITS.
- bit_cnt_o never wraps during an operation; it returns to 0 only in CLR or on reset.

Test Plan:
- Reset with run_i=1 held, then released and pressed again: no start while held through reset. The fresh press gives CLR exactly one cycle after the rising edge is sampled, and busy_o goes high.
- N=8, bench B model = 8'b1000_0011 (shifts right on shift_o), run pulse at k:
  - add_o at k+2 and k+4.
  - no add at k+6..k+14.
  - sub_o at k+16.
  - shift_o at k+3, k+5, ..., k+17 (8 pulses).
  - done_o from k+18.
- B=8'h00: zero add_o/sub_o pulses and exactly 8 shift_o pulses. With run_i held, the FSM stays in HOLD 20+ cycles; run_i=0 -> IDLE next cycle, done_o=0.
- IDLE with clear_load_i=1 for 3 cycles: clr_a_o=ld_b_o=1 for exactly those 3 cycles. With start and clear_load_i in the same cycle: ld_b_o=0, CLR next cycle.
- Reset asserted at ADD_3 (k+8): next cycle state IDLE, all strobes 0, bit_cnt_o=0. A new run edge restarts from CLR with bit_cnt_o=0.
- Second run edge and a clear_load_i pulse injected at k+5 and k+9 (mid-operation): no change to the strobe sequence and no extra CLR.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: control FSM for an N-bit signed shift-add multiplier.
// It issues one-cycle strobes to the datapath (A accumulator, B multiplier
// shift register, sign bit X). The datapath owns all data; this block only
// sequences it.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   run_i        synchronized run button (level); its rising edge starts an operation
//   clear_load_i clear A/X and load B; only honoured in IDLE
//   m_i          current LSB of multiplier register B
//   clr_a_o      clear A and X this cycle
//   ld_b_o       load B from switches this cycle
//   add_o        A <= A + S this cycle
//   sub_o        A <= A - S this cycle (sign-bit correction on the last iteration)
//   shift_o      arithmetic right shift of {X,A,B} this cycle
//   busy_o       high in CLR, ADD and SHIFT
//   done_o       high in HOLD
//   bit_cnt_o    current iteration index
module mult_seq_ctrl #(
    parameter int unsigned N_BITS = 8,
    parameter int unsigned CNT_W  = $clog2(N_BITS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_i,
    input  logic             clear_load_i,
    input  logic             m_i,
    output logic             clr_a_o,
    output logic             ld_b_o,
    output logic             add_o,
    output logic             sub_o,
    output logic             shift_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] bit_cnt_o
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_HOLD  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             run_q;
    logic             start;
    logic             last_bit;

    // run_q resets to 1 so a button held through reset cannot start an operation.
    assign start    = run_i & ~run_q;
    assign last_bit = (bit_cnt_q == LAST_BIT);

    // Next-state, counter and strobe decode.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        clr_a_o   = 1'b0;
        ld_b_o    = 1'b0;
        add_o     = 1'b0;
        sub_o     = 1'b0;
        shift_o   = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // A start edge takes priority over a simultaneous clear/load.
                if (start) begin
                    state_d = S_CLR;
                end else if (clear_load_i) begin
                    clr_a_o = 1'b1;
                    ld_b_o  = 1'b1;
                end
            end
            S_CLR: begin
                clr_a_o   = 1'b1;
                busy_o    = 1'b1;
                bit_cnt_d = '0;
                state_d   = S_ADD;
            end
            S_ADD: begin
                busy_o = 1'b1;
                // The MSB of a two's-complement multiplier carries negative weight.
                if (m_i) begin
                    if (last_bit) begin
                        sub_o = 1'b1;
                    end else begin
                        add_o = 1'b1;
                    end
                end
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                busy_o  = 1'b1;
                shift_o = 1'b1;
                if (last_bit) begin
                    state_d = S_HOLD;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    state_d   = S_ADD;
                end
            end
            S_HOLD: begin
                done_o = 1'b1;
                if (!run_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Nothing reaches the datapath in a reset cycle; the operation is abandoned.
        if (reset) begin
            clr_a_o = 1'b0;
            ld_b_o  = 1'b0;
            add_o   = 1'b0;
            sub_o   = 1'b0;
            shift_o = 1'b0;
            busy_o  = 1'b0;
            done_o  = 1'b0;
        end
    end

    // State, iteration counter and run-edge history.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            run_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            run_q     <= run_i;
        end
    end

    assign bit_cnt_o = bit_cnt_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Testbench for mult_seq_ctrl: per-cycle expected output vectors are queued
// when stimulus is planned and popped/compared once per cycle.
module tb_mult_seq_ctrl;

    localparam int unsigned N_BITS = 8;
    localparam int unsigned CNT_W  = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             run_i;
    logic             clear_load_i;
    logic             m_i;
    logic             clr_a_o;
    logic             ld_b_o;
    logic             add_o;
    logic             sub_o;
    logic             shift_o;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] bit_cnt_o;

    mult_seq_ctrl #(.N_BITS(N_BITS), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .run_i        (run_i),
        .clear_load_i (clear_load_i),
        .m_i          (m_i),
        .clr_a_o      (clr_a_o),
        .ld_b_o       (ld_b_o),
        .add_o        (add_o),
        .sub_o        (sub_o),
        .shift_o      (shift_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .bit_cnt_o    (bit_cnt_o)
    );

    always #5 clk = ~clk;

    // Multiplier register B model: loads on request, shifts right on shift_o.
    logic [7:0] b_model;
    logic [7:0] b_pat;
    logic       b_ld;
    always @(posedge clk) begin
        if (b_ld) b_model <= b_pat;
        else if (shift_o) b_model <= b_model >> 1;
    end
    assign m_i = b_model[0];

    // Observed vector: {clr, ld, add, sub, shift, busy, done, cnt[2:0]}
    typedef logic [9:0] vec_t;
    vec_t obs;
    assign obs = {clr_a_o, ld_b_o, add_o, sub_o, shift_o, busy_o, done_o, bit_cnt_o};

    vec_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t ev(input logic clr, input logic ld, input logic add,
                                input logic sub, input logic sh, input logic busy,
                                input logic done, input logic [2:0] cnt);
        return {clr, ld, add, sub, sh, busy, done, cnt};
    endfunction

    // Expected cycles of one operation: start cycle (IDLE), CLR, then ADD/SHIFT pairs.
    function automatic void push_op(input logic [7:0] b, input logic [2:0] cnt0);
        sb.push_back(ev(0, 0, 0, 0, 0, 0, 0, cnt0));
        sb.push_back(ev(1, 0, 0, 0, 0, 1, 0, cnt0));
        for (int i = 0; i < 8; i++) begin
            sb.push_back(ev(0, 0, b[i] && (i < 7), b[i] && (i == 7), 0, 1, 0, 3'(i)));
            sb.push_back(ev(0, 0, 0, 0, 1, 1, 0, 3'(i)));
        end
    endfunction

    function automatic void push_n(input vec_t e, input int n);
        for (int i = 0; i < n; i++) sb.push_back(e);
    endfunction

    task automatic load_b(input logic [7:0] b);
        @(posedge clk); #1;
        b_pat = b;
        b_ld  = 1'b1;
        @(posedge clk); #1;
        b_ld  = 1'b0;
    endtask

    task automatic test_reset();
        vec_t e;
        push_n(ev(0, 0, 0, 0, 0, 0, 0, 3'd0), 6);
        for (int j = 0; sb.size() > 0; j++) begin
            @(posedge clk); #1;
            if (j < 2) begin reset = 1'b1; run_i = 1'b1; end
            else if (j < 5) begin reset = 1'b0; run_i = 1'b1; end
            else run_i = 1'b0;
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset cyc=%0d got=%b exp=%b", j, obs, e);
            end
        end
    endtask

    task automatic test_pattern();
        vec_t e;
        load_b(8'b1000_0011);
        push_op(8'b1000_0011, 3'd0);
        push_n(ev(0, 0, 0, 0, 0, 0, 1, 3'd7), 4);
        sb.push_back(ev(0, 0, 0, 0, 0, 0, 0, 3'd7));
        for (int j = 0; sb.size() > 0; j++) begin
            @(posedge clk); #1;
            if (j == 0) run_i = 1'b1;
            if (j == 21) run_i = 1'b0;
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL pattern cyc=%0d got=%b exp=%b", j, obs, e);
            end
        end
    endtask

    task automatic test_zero_hold();
        vec_t e;
        load_b(8'h00);
        push_op(8'h00, 3'd7);
        push_n(ev(0, 0, 0, 0, 0, 0, 1, 3'd7), 23);
        sb.push_back(ev(0, 0, 0, 0, 0, 0, 0, 3'd7));
        for (int j = 0; sb.size() > 0; j++) begin
            @(posedge clk); #1;
            if (j == 0) run_i = 1'b1;
            clear_load_i = (j >= 20 && j <= 22);
            if (j == 40) run_i = 1'b0;
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL zero_hold cyc=%0d got=%b exp=%b", j, obs, e);
            end
        end
    endtask

    task automatic test_clear_load();
        vec_t e;
        load_b(8'h5A);
        push_n(ev(1, 1, 0, 0, 0, 0, 0, 3'd7), 3);
        sb.push_back(ev(0, 0, 0, 0, 0, 0, 0, 3'd7));
        push_op(8'h5A, 3'd7);
        sb.push_back(ev(0, 0, 0, 0, 0, 0, 1, 3'd7));
        sb.push_back(ev(0, 0, 0, 0, 0, 0, 0, 3'd7));
        for (int j = 0; sb.size() > 0; j++) begin
            @(posedge clk); #1;
            if (j == 0) clear_load_i = 1'b1;
            if (j == 3) clear_load_i = 1'b0;
            if (j == 4) begin run_i = 1'b1; clear_load_i = 1'b1; end
            if (j == 5) clear_load_i = 1'b0;
            if (j == 22) run_i = 1'b0;
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL clear_load cyc=%0d got=%b exp=%b", j, obs, e);
            end
        end
    endtask

    task automatic test_abort();
        vec_t e;
        load_b(8'b1000_0011);
        push_op(8'b1000_0011, 3'd7);
        while (sb.size() > 8) sb.delete(sb.size() - 1);
        sb.push_back(ev(0, 0, 0, 0, 0, 0, 0, 3'd3));
        sb.push_back(ev(0, 0, 0, 0, 0, 0, 0, 3'd0));
        for (int j = 0; sb.size() > 0; j++) begin
            @(posedge clk); #1;
            if (j == 0) run_i = 1'b1;
            if (j == 8) begin reset = 1'b1; run_i = 1'b0; end
            if (j == 9) reset = 1'b0;
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL abort cyc=%0d got=%b exp=%b", j, obs, e);
            end
        end
        // A fresh run edge after the abort restarts from CLR with a cleared count.
        load_b(8'b1000_0011);
        push_op(8'b1000_0011, 3'd0);
        sb.push_back(ev(0, 0, 0, 0, 0, 0, 1, 3'd7));
        sb.push_back(ev(0, 0, 0, 0, 0, 0, 0, 3'd7));
        for (int j = 0; sb.size() > 0; j++) begin
            @(posedge clk); #1;
            if (j == 0) run_i = 1'b1;
            if (j == 18) run_i = 1'b0;
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL restart cyc=%0d got=%b exp=%b", j, obs, e);
            end
        end
    endtask

    task automatic test_busy_ignore();
        vec_t e;
        load_b(8'b1000_0011);
        push_op(8'b1000_0011, 3'd7);
        sb.push_back(ev(0, 0, 0, 0, 0, 0, 1, 3'd7));
        sb.push_back(ev(0, 0, 0, 0, 0, 0, 0, 3'd7));
        for (int j = 0; sb.size() > 0; j++) begin
            @(posedge clk); #1;
            case (j)
                0:  run_i = 1'b1;
                4:  run_i = 1'b0;
                5:  begin run_i = 1'b1; clear_load_i = 1'b1; end
                6:  clear_load_i = 1'b0;
                8:  run_i = 1'b0;
                9:  begin run_i = 1'b1; clear_load_i = 1'b1; end
                10: clear_load_i = 1'b0;
                18: run_i = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL busy_ignore cyc=%0d got=%b exp=%b", j, obs, e);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        run_i        = 1'b1;
        clear_load_i = 1'b0;
        b_ld         = 1'b0;
        b_pat        = 8'h00;
        test_reset();
        test_pattern();
        test_zero_hold();
        test_clear_load();
        test_abort();
        test_busy_ignore();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
